// File: rtl/seg_scan_decoder_if.sv
// ============================================================================
// seg_scan_decoder_if : display-bus and frame-handshake bundle for seg_scan_decoder
// Revision 1.0 -- initial release (err_count present only with SEG_ERR_COUNT_EN)
// ============================================================================
`default_nettype none

interface seg_scan_decoder_if;
  logic [6:0]  segments;
  logic [7:0]  anodos;
  logic [31:0] digits;
  logic [7:0]  blank;
  logic [7:0]  err;
  logic        out_valid;
  logic        out_ready;
  logic        overrun;
`ifdef SEG_ERR_COUNT_EN
  logic [7:0]  err_count;
`endif

  modport master (
    output segments, anodos, out_ready,
    input  digits, blank, err, out_valid, overrun
`ifdef SEG_ERR_COUNT_EN
    , input err_count
`endif
  );

  modport slave (
    input  segments, anodos, out_ready,
    output digits, blank, err, out_valid, overrun
`ifdef SEG_ERR_COUNT_EN
    , output err_count
`endif
  );
endinterface

`default_nettype wire

// File: rtl/seg_scan_decoder.sv
// ============================================================================
// seg_scan_decoder : recovers an 8-digit hex frame from a multiplexed 7-seg bus
// Optional err_count output with macro SEG_ERR_COUNT_EN. Revision 1.0
// ============================================================================
`default_nettype none

module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 16  // must be >= 2
) (
  input  wire logic          clock,
  input  wire logic          reset,
  seg_scan_decoder_if.slave  bus
);

  localparam int CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {SYNC = 2'd0, COLLECT = 2'd1, HOLD = 2'd2} state_t;

  // Returns {blank, err, nibble}
  function automatic logic [5:0] decode(input logic [6:0] seg);
    logic [5:0] r;
    r = 6'b01_0000;
    case (seg)
      7'b0000001: r = 6'h00;  7'b1001111: r = 6'h01;
      7'b0010010: r = 6'h02;  7'b0000110: r = 6'h03;
      7'b1001100: r = 6'h04;  7'b0100100: r = 6'h05;
      7'b0100000: r = 6'h06;  7'b0001111: r = 6'h07;
      7'b0000000: r = 6'h08;  7'b0000100: r = 6'h09;
      7'b0001000: r = 6'h0A;  7'b1100000: r = 6'h0B;
      7'b0110001: r = 6'h0C;  7'b1000010: r = 6'h0D;
      7'b0110000: r = 6'h0E;  7'b0111000: r = 6'h0F;
      7'b1111111: r = 6'b10_0000;
      default:    r = 6'b01_0000;
    endcase
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [7:0]       anodos_prev_q, anodos_prev_d;
  logic [6:0]       segments_prev_q, segments_prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       mask_q, mask_d;
  logic [31:0]      shadow_digits_q, shadow_digits_d;
  logic [7:0]       shadow_blank_q, shadow_blank_d;
  logic [7:0]       shadow_err_q, shadow_err_d;
  logic [31:0]      digits_q, digits_d;
  logic [7:0]       blank_q, blank_d;
  logic [7:0]       err_q, err_d;
  logic             out_valid_q, out_valid_d;
  logic             overrun_q, overrun_d;
`ifdef SEG_ERR_COUNT_EN
  logic [7:0]       err_count_q, err_count_d;
`endif

  logic       same, one_hot, capture, accept, frame_done;
  logic [2:0] idx;
  logic [5:0] dec;
  logic [7:0] mask_base;

  always_comb begin
    same    = (bus.anodos == anodos_prev_q) && (bus.segments == segments_prev_q);
    one_hot = $onehot(~bus.anodos);
    idx     = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!bus.anodos[i]) idx = 3'(i);
    end
    dec        = decode(bus.segments);
    capture    = same && one_hot && (cnt_q == CNT_MAX - 1'b1);
    // Outside SYNC every capture counts; in SYNC only digit 0 opens a frame.
    accept     = capture && ((state_q != SYNC) || (idx == 3'd0));
    frame_done = (mask_q == 8'hFF);
    mask_base  = frame_done ? 8'h00 : mask_q;

    state_d         = state_q;
    anodos_prev_d   = bus.anodos;
    segments_prev_d = bus.segments;
    shadow_digits_d = shadow_digits_q;
    shadow_blank_d  = shadow_blank_q;
    shadow_err_d    = shadow_err_q;
    digits_d        = digits_q;
    blank_d         = blank_q;
    err_d           = err_q;
    out_valid_d     = out_valid_q;
    overrun_d       = overrun_q;
    mask_d          = mask_base;
`ifdef SEG_ERR_COUNT_EN
    err_count_d     = err_count_q;
    if (accept && dec[4] && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
`endif

    if (!same || !one_hot)      cnt_d = '0;
    else if (cnt_q != CNT_MAX)  cnt_d = cnt_q + 1'b1;
    else                        cnt_d = cnt_q;

    if (accept) begin
      shadow_digits_d[4*idx +: 4] = dec[3:0];
      shadow_blank_d[idx]         = dec[5];
      shadow_err_d[idx]           = dec[4];
      mask_d = (idx == 3'd0) ? 8'h01 : (mask_base | (8'h01 << idx));
    end

    case (state_q)
      SYNC: begin
        if (accept) state_d = COLLECT;
      end
      COLLECT: begin
        if (frame_done) begin
          digits_d    = shadow_digits_q;
          blank_d     = shadow_blank_q;
          err_d       = shadow_err_q;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        // A shadow frame finishing while the last one is unconsumed is lost.
        if (frame_done) overrun_d = 1'b1;
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = COLLECT;
          mask_d      = (accept && (idx == 3'd0)) ? 8'h01 : 8'h00;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= SYNC;
      anodos_prev_q   <= '0;
      segments_prev_q <= '0;
      cnt_q           <= '0;
      mask_q          <= '0;
      shadow_digits_q <= '0;
      shadow_blank_q  <= '0;
      shadow_err_q    <= '0;
      digits_q        <= '0;
      blank_q         <= '0;
      err_q           <= '0;
      out_valid_q     <= 1'b0;
      overrun_q       <= 1'b0;
`ifdef SEG_ERR_COUNT_EN
      err_count_q     <= '0;
`endif
    end else begin
      state_q         <= state_d;
      anodos_prev_q   <= anodos_prev_d;
      segments_prev_q <= segments_prev_d;
      cnt_q           <= cnt_d;
      mask_q          <= mask_d;
      shadow_digits_q <= shadow_digits_d;
      shadow_blank_q  <= shadow_blank_d;
      shadow_err_q    <= shadow_err_d;
      digits_q        <= digits_d;
      blank_q         <= blank_d;
      err_q           <= err_d;
      out_valid_q     <= out_valid_d;
      overrun_q       <= overrun_d;
`ifdef SEG_ERR_COUNT_EN
      err_count_q     <= err_count_d;
`endif
    end
  end

  assign bus.digits    = digits_q;
  assign bus.blank     = blank_q;
  assign bus.err       = err_q;
  assign bus.out_valid = out_valid_q;
  assign bus.overrun   = overrun_q;
`ifdef SEG_ERR_COUNT_EN
  assign bus.err_count = err_count_q;
`endif

endmodule

`default_nettype wire
